// File: rtl/font_text_ctrl.sv
// font_text_ctrl
//   Character-cell text controller feeding font_mem_addr_gen. Holds a
//   TEXT_COLS x TEXT_ROWS glyph buffer that game logic fills through a
//   cursor plus valid/ready put-char port. For every VGA pixel it locates the
//   cell under (h_cnt>>1, v_cnt>>1) and presents, one cycle later, that
//   cell's origin and glyph code. It also sweeps the buffer to BLANK_CODE
//   after reset and whenever clr_req is pulsed.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   h_cnt, v_cnt          full-resolution VGA counters
//   wr_valid/wr_char      put-char request and glyph; wr_ready accepts it
//   set_valid/col/row     cursor load (ignored when out of range)
//   clr_req / clr_busy    start clear sweep / sweep in progress
//   pos_h_cnt/pos_v_cnt   origin of current cell (1-cycle latency)
//   alphabet              glyph of current cell (1-cycle latency)
//   active                current pixel lies inside the text window
module font_text_ctrl #(
  parameter int CNT_BITS_N      = 10,
  parameter int ALPHABET_BITS_N = 6,
  parameter int FONT_WIDTH_CNT  = 8,
  parameter int FONT_HEIGHT_CNT = 8,
  parameter int TEXT_COLS       = 16,
  parameter int TEXT_ROWS       = 4,
  parameter int ORIGIN_H        = 0,
  parameter int ORIGIN_V        = 0,
  parameter int BLANK_CODE      = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CNT_BITS_N-1:0]        h_cnt,
  input  logic [CNT_BITS_N-1:0]        v_cnt,
  input  logic                         wr_valid,
  input  logic [ALPHABET_BITS_N-1:0]   wr_char,
  output logic                         wr_ready,
  input  logic                         set_valid,
  input  logic [$clog2(TEXT_COLS)-1:0] set_col,
  input  logic [$clog2(TEXT_ROWS)-1:0] set_row,
  input  logic                         clr_req,
  output logic                         clr_busy,
  output logic [CNT_BITS_N-1:0]        pos_h_cnt,
  output logic [CNT_BITS_N-1:0]        pos_v_cnt,
  output logic [ALPHABET_BITS_N-1:0]   alphabet,
  output logic                         active
);

  localparam int COL_W   = $clog2(TEXT_COLS);
  localparam int ROW_W   = $clog2(TEXT_ROWS);
  localparam int N_CELLS = TEXT_COLS * TEXT_ROWS;
  localparam int IDX_W   = $clog2(N_CELLS);

  localparam logic [CNT_BITS_N-1:0] H_LO   = CNT_BITS_N'(ORIGIN_H);
  localparam logic [CNT_BITS_N-1:0] V_LO   = CNT_BITS_N'(ORIGIN_V);
  localparam logic [CNT_BITS_N-1:0] H_SPAN = CNT_BITS_N'(TEXT_COLS * FONT_WIDTH_CNT);
  localparam logic [CNT_BITS_N-1:0] V_SPAN = CNT_BITS_N'(TEXT_ROWS * FONT_HEIGHT_CNT);
  localparam logic [CNT_BITS_N-1:0] FW     = CNT_BITS_N'(FONT_WIDTH_CNT);
  localparam logic [CNT_BITS_N-1:0] FH     = CNT_BITS_N'(FONT_HEIGHT_CNT);
  localparam logic [ALPHABET_BITS_N-1:0] BLANK = ALPHABET_BITS_N'(BLANK_CODE);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Glyph buffer, cell index = row*TEXT_COLS + col
  logic [ALPHABET_BITS_N-1:0] buf_mem [N_CELLS];

  logic [0:0]                 state_q,    state_d;
  logic [IDX_W-1:0]           clr_idx_q,  clr_idx_d;
  logic [COL_W-1:0]           cur_col_q,  cur_col_d;
  logic [ROW_W-1:0]           cur_row_q,  cur_row_d;
  logic [CNT_BITS_N-1:0]      pos_h_q,    pos_h_d;
  logic [CNT_BITS_N-1:0]      pos_v_q,    pos_v_d;
  logic [ALPHABET_BITS_N-1:0] alphabet_q, alphabet_d;
  logic                       active_q,   active_d;

  logic                       wr_fire;
  logic                       set_ok;
  logic                       mem_we;
  logic [IDX_W-1:0]           mem_waddr;
  logic [ALPHABET_BITS_N-1:0] mem_wdata;

  // ---------------- control: clear sweep, cursor, buffer writes ----------
  assign wr_ready = (state_q == ST_IDLE) & ~clr_req & ~set_valid;
  assign wr_fire  = wr_valid & wr_ready;
  assign clr_busy = (state_q == ST_CLEAR);
  assign set_ok   = (32'(set_col) < TEXT_COLS) && (32'(set_row) < TEXT_ROWS);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    mem_we    = 1'b0;
    mem_waddr = IDX_W'(cur_row_q) * IDX_W'(TEXT_COLS) + IDX_W'(cur_col_q);
    mem_wdata = wr_char;

    if (state_q == ST_CLEAR) begin
      // The current cell is blanked even if a restart is requested this cycle
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdata = BLANK;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end

    if (clr_req) begin
      state_d   = ST_CLEAR;
      clr_idx_d = '0;
    end else if (state_q == ST_CLEAR) begin
      if (clr_idx_q == IDX_W'(N_CELLS - 1)) begin
        state_d   = ST_IDLE;
        clr_idx_d = '0;
        cur_col_d = '0;
        cur_row_d = '0;
      end else begin
        clr_idx_d = clr_idx_q + IDX_W'(1);
      end
    end else if (set_valid) begin
      if (set_ok) begin
        cur_col_d = set_col;
        cur_row_d = set_row;
      end
    end else if (wr_valid) begin
      if (cur_col_q == COL_W'(TEXT_COLS - 1)) begin
        cur_col_d = '0;
        cur_row_d = (cur_row_q == ROW_W'(TEXT_ROWS - 1)) ? '0 : cur_row_q + ROW_W'(1);
      end else begin
        cur_col_d = cur_col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      buf_mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------- read path: pixel -> cell lookup ----------------------
  logic [CNT_BITS_N-1:0] hh, vv, dh, dv;
  logic [CNT_BITS_N:0]   dh_ext, dv_ext;
  logic                  in_win;
  logic [COL_W-1:0]      rd_col;
  logic [ROW_W-1:0]      rd_row;
  logic [IDX_W-1:0]      rd_idx;

  always_comb begin
    hh = h_cnt >> 1;
    vv = v_cnt >> 1;
    // One extra bit catches pixels left of / above the window origin
    dh_ext = {1'b0, hh} - {1'b0, H_LO};
    dv_ext = {1'b0, vv} - {1'b0, V_LO};
    dh     = dh_ext[CNT_BITS_N-1:0];
    dv     = dv_ext[CNT_BITS_N-1:0];
    in_win = ~dh_ext[CNT_BITS_N] & ~dv_ext[CNT_BITS_N] & (dh < H_SPAN) & (dv < V_SPAN);
    rd_col = COL_W'(dh / FW);
    rd_row = ROW_W'(dv / FH);
    rd_idx = IDX_W'(rd_row) * IDX_W'(TEXT_COLS) + IDX_W'(rd_col);

    pos_h_d    = '0;
    pos_v_d    = '0;
    alphabet_d = BLANK;
    active_d   = 1'b0;
    if (in_win) begin
      pos_h_d    = H_LO + (dh / FW) * FW;
      pos_v_d    = V_LO + (dv / FH) * FH;
      alphabet_d = buf_mem[rd_idx];  // old contents if written this same cycle
      active_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= '0;
      cur_col_q  <= '0;
      cur_row_q  <= '0;
      pos_h_q    <= '0;
      pos_v_q    <= '0;
      alphabet_q <= BLANK;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      cur_col_q  <= cur_col_d;
      cur_row_q  <= cur_row_d;
      pos_h_q    <= pos_h_d;
      pos_v_q    <= pos_v_d;
      alphabet_q <= alphabet_d;
      active_q   <= active_d;
    end
  end

  assign pos_h_cnt = pos_h_q;
  assign pos_v_cnt = pos_v_q;
  assign alphabet  = alphabet_q;
  assign active    = active_q;

endmodule

// File: tb/tb_font_text_ctrl.sv
// tb_font_text_ctrl
//   Directed bench for font_text_ctrl with the default parameter set
//   (16x4 cells of 8x8 half-res pixels, origin 0, blank code 0).
module tb_font_text_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] h_cnt, v_cnt;
  logic       wr_valid;
  logic [5:0] wr_char;
  logic       wr_ready;
  logic       set_valid;
  logic [3:0] set_col;
  logic [1:0] set_row;
  logic       clr_req;
  logic       clr_busy;
  logic [9:0] pos_h_cnt, pos_v_cnt;
  logic [5:0] alphabet;
  logic       active;

  int n_cmp = 0;
  int n_mis = 0;
  int cnt;
  logic [5:0] a;

  font_text_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .wr_valid  (wr_valid),
    .wr_char   (wr_char),
    .wr_ready  (wr_ready),
    .set_valid (set_valid),
    .set_col   (set_col),
    .set_row   (set_row),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .pos_h_cnt (pos_h_cnt),
    .pos_v_cnt (pos_v_cnt),
    .alphabet  (alphabet),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_char(input logic [5:0] c);
    wr_valid = 1'b1;
    wr_char  = c;
    tick();
    wr_valid = 1'b0;
    $display("put-char %0d", c);
  endtask

  task automatic set_cursor(input int col, input int row);
    set_valid = 1'b1;
    set_col   = 4'(col);
    set_row   = 2'(row);
    tick();
    set_valid = 1'b0;
    $display("set cursor (%0d,%0d)", col, row);
  endtask

  // Point the pixel counters at the top-left pixel of a cell and sample
  task automatic read_cell(input int col, input int row, output logic [5:0] g);
    h_cnt = 10'(col * 16);
    v_cnt = 10'(row * 16);
    tick();
    g = alphabet;
  endtask

  task automatic wait_clear_done(output int n);
    n = 0;
    while (clr_busy && n < 200) begin
      tick();
      n++;
    end
    $display("clear sweep took %0d cycles", n);
  endtask

  initial begin
    rst = 1'b0; h_cnt = 10'd16; v_cnt = 10'd0;
    wr_valid = 1'b0; wr_char = '0; set_valid = 1'b0; set_col = '0; set_row = '0; clr_req = 1'b0;
    repeat (3) tick();
    check_val("rst_pos_h",    32'(pos_h_cnt), 32'd0);
    check_val("rst_pos_v",    32'(pos_v_cnt), 32'd0);
    check_val("rst_alphabet", 32'(alphabet),  32'd0);
    check_val("rst_active",   32'(active),    32'd0);
    check_val("rst_wr_ready", 32'(wr_ready),  32'd0);
    check_val("rst_clr_busy", 32'(clr_busy),  32'd1);

    // Initial clear sweep
    rst = 1'b1;
    wait_clear_done(cnt);
    check_val("init_clear_cycles", 32'(cnt), 32'd64);
    check_val("init_wr_ready", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 64; i++) begin
      read_cell(i % 16, i / 16, a);
      check_val($sformatf("blank_cell%0d", i), 32'(a), 32'd0);
    end

    // Two writes from cursor (0,0)
    write_char(6'd5);
    write_char(6'd6);
    h_cnt = 10'd16; v_cnt = 10'd0;
    tick();
    check_val("px16_pos_h",  32'(pos_h_cnt), 32'd8);
    check_val("px16_pos_v",  32'(pos_v_cnt), 32'd0);
    check_val("px16_glyph",  32'(alphabet),  32'd6);
    check_val("px16_active", 32'(active),    32'd1);
    read_cell(0, 0, a);
    check_val("cell00_A", 32'(a), 32'd5);
    // Interior pixel of cell (3,2): hh=29, vv=19
    h_cnt = 10'd58; v_cnt = 10'd38;
    tick();
    check_val("mid_pos_h",  32'(pos_h_cnt), 32'd24);
    check_val("mid_pos_v",  32'(pos_v_cnt), 32'd16);
    check_val("mid_active", 32'(active),    32'd1);

    // Cursor wrap from the last cell
    set_cursor(15, 3);
    write_char(6'd7);
    write_char(6'd8);
    read_cell(15, 3, a);
    check_val("cell15_3", 32'(a), 32'd7);
    read_cell(0, 0, a);
    check_val("wrap_cell00", 32'(a), 32'd8);
    write_char(6'd9);
    read_cell(1, 0, a);
    check_val("wrap_cursor10", 32'(a), 32'd9);

    // set_valid beats wr_valid in the same cycle
    set_valid = 1'b1; set_col = 4'd4; set_row = 2'd2;
    wr_valid = 1'b1; wr_char = 6'd33;
    #1;
    check_val("set_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    set_valid = 1'b0; wr_valid = 1'b0;
    $display("set (4,2) with simultaneous put-char 33");
    read_cell(4, 2, a);
    check_val("set_nowrite42", 32'(a), 32'd0);
    read_cell(2, 0, a);
    check_val("set_nowrite20", 32'(a), 32'd0);
    write_char(6'd11);
    read_cell(4, 2, a);
    check_val("set_cursor42", 32'(a), 32'd11);

    // clr_req beats wr_valid; sweep restarts the whole buffer
    clr_req = 1'b1; wr_valid = 1'b1; wr_char = 6'd44;
    #1;
    check_val("clr_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    clr_req = 1'b0; wr_valid = 1'b0;
    $display("clear request with simultaneous put-char 44");
    check_val("clr_busy_next", 32'(clr_busy), 32'd1);
    wait_clear_done(cnt);
    check_val("clr_cycles", 32'(cnt), 32'd64);
    read_cell(4, 2, a);
    check_val("clr_cell42", 32'(a), 32'd0);
    read_cell(5, 2, a);
    check_val("clr_cell52", 32'(a), 32'd0);
    write_char(6'd12);
    read_cell(0, 0, a);
    check_val("clr_cursor00", 32'(a), 32'd12);

    // Window boundaries
    set_cursor(15, 3);
    write_char(6'd21);
    h_cnt = 10'd255; v_cnt = 10'd63;
    tick();
    check_val("edge_pos_h",  32'(pos_h_cnt), 32'd120);
    check_val("edge_pos_v",  32'(pos_v_cnt), 32'd24);
    check_val("edge_glyph",  32'(alphabet),  32'd21);
    check_val("edge_active", 32'(active),    32'd1);
    h_cnt = 10'd256; v_cnt = 10'd0;
    tick();
    check_val("outh_active", 32'(active),    32'd0);
    check_val("outh_glyph",  32'(alphabet),  32'd0);
    check_val("outh_pos_h",  32'(pos_h_cnt), 32'd0);
    check_val("outh_pos_v",  32'(pos_v_cnt), 32'd0);
    h_cnt = 10'd0; v_cnt = 10'd64;
    tick();
    check_val("outv_active", 32'(active), 32'd0);

    // Same-cycle read and write of cell (0,0): cursor wrapped there
    h_cnt = 10'd0; v_cnt = 10'd0;
    wr_valid = 1'b1; wr_char = 6'd30;
    tick();
    wr_valid = 1'b0;
    $display("put-char 30 while reading the same cell");
    check_val("rw_old", 32'(alphabet), 32'd12);
    tick();
    check_val("rw_new", 32'(alphabet), 32'd30);

    // Reads keep working during a sweep; reset mid-sweep restarts it
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    h_cnt = 10'd255; v_cnt = 10'd63;
    repeat (10) tick();
    check_val("sweep_read_glyph",  32'(alphabet), 32'd21);
    check_val("sweep_read_active", 32'(active),   32'd1);
    rst = 1'b0;
    #1;
    check_val("midrst_active", 32'(active),    32'd0);
    check_val("midrst_glyph",  32'(alphabet),  32'd0);
    check_val("midrst_pos_h",  32'(pos_h_cnt), 32'd0);
    check_val("midrst_busy",   32'(clr_busy),  32'd1);
    check_val("midrst_ready",  32'(wr_ready),  32'd0);
    tick();
    tick();
    rst = 1'b1;
    wait_clear_done(cnt);
    check_val("midrst_clear_cycles", 32'(cnt), 32'd64);
    check_val("midrst_wr_ready", 32'(wr_ready), 32'd1);
    read_cell(15, 3, a);
    check_val("midrst_cell15_3", 32'(a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
